// File: rtl/m2_block_scheduler.sv
// m2_block_scheduler: steps the fetch / T-compute / S-compute / writeback engines
// through the 2400 8x8 blocks of a Y/U/V frame in a two-phase overlapped pipeline.
module m2_block_scheduler (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    output logic        Done,
    output logic        Busy,
    output logic        fetch_start,
    output logic [17:0] fetch_addr,
    output logic [8:0]  fetch_stride,
    input  logic        fetch_done,
    output logic        ct_start,
    input  logic        ct_done,
    output logic        cs_start,
    input  logic        cs_done,
    output logic        write_start,
    input  logic        write_done,
    output logic [17:0] write_addr,
    output logic [7:0]  write_stride,
    output logic        sram_sel
);
    localparam int unsigned AW  = 18;
    localparam int unsigned BW  = 12;
    localparam int unsigned FSW = 9;
    localparam int unsigned WSW = 8;

    localparam logic [BW-1:0] LAST_BLK = BW'(2399);
    localparam logic [4:0]    ROW_LAST = 5'd29;
    localparam logic [AW-1:0] F_BASE_Y = AW'(76800);
    localparam logic [AW-1:0] F_BASE_U = AW'(153600);
    localparam logic [AW-1:0] F_BASE_V = AW'(192000);
    localparam logic [AW-1:0] W_BASE_Y = AW'(0);
    localparam logic [AW-1:0] W_BASE_U = AW'(38400);
    localparam logic [AW-1:0] W_BASE_V = AW'(57600);

    typedef enum logic [2:0] {
        S_IDLE, S_LI_FETCH, S_PHASE_A, S_PHASE_B, S_LO_WRITE, S_FINISH
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] blk, blk_nxt;
    logic          flag_f, flag_ct, flag_cs, flag_w;
    logic          flag_f_nxt, flag_ct_nxt, flag_cs_nxt, flag_w_nxt;
    logic          iss_f, iss_ct, iss_cs, iss_w, all_done, enter;
    logic          fetch_start_nxt, ct_start_nxt, cs_start_nxt, write_start_nxt;
    logic          done_nxt, busy_nxt, sram_sel_nxt, q_pop;

    logic [1:0]     f_seg;
    logic [4:0]     f_row;
    logic [5:0]     f_col, last_col;
    logic [AW-1:0]  f_row_addr, f_addr, w_row_addr, w_addr;
    logic [AW-1:0]  f_row_step, w_row_step, f_seg_base, w_seg_base;
    logic [FSW-1:0] f_stride_cur;
    logic [WSW-1:0] w_stride_cur;

    logic [AW-1:0]  q_addr   [2];
    logic [WSW-1:0] q_stride [2];
    logic [1:0]     q_cnt;

    // Next state, engine bookkeeping and registered-output next values
    always_comb begin
        state_nxt = state;
        blk_nxt   = blk;
        iss_f     = 1'b0;
        iss_ct    = 1'b0;
        iss_cs    = 1'b0;
        iss_w     = 1'b0;
        case (state)
            S_LI_FETCH: iss_f = 1'b1;
            S_PHASE_A: begin
                iss_ct = 1'b1;
                iss_f  = (blk != LAST_BLK);
            end
            S_PHASE_B: begin
                iss_cs = 1'b1;
                iss_w  = (blk != '0);
            end
            S_LO_WRITE: iss_w = 1'b1;
            default: ;
        endcase
        all_done = (flag_f | ~iss_f) & (flag_ct | ~iss_ct) &
                   (flag_cs | ~iss_cs) & (flag_w | ~iss_w);
        case (state)
            S_IDLE: if (Enable) begin
                state_nxt = S_LI_FETCH;
                blk_nxt   = '0;
            end
            S_LI_FETCH: if (all_done) state_nxt = S_PHASE_A;
            S_PHASE_A:  if (all_done) state_nxt = S_PHASE_B;
            S_PHASE_B: if (all_done) begin
                if (blk == LAST_BLK) begin
                    state_nxt = S_LO_WRITE;
                end else begin
                    state_nxt = S_PHASE_A;
                    blk_nxt   = blk + BW'(1);
                end
            end
            S_LO_WRITE: if (all_done) state_nxt = S_FINISH;
            S_FINISH:   state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        enter           = (state_nxt != state);
        fetch_start_nxt = enter && ((state_nxt == S_LI_FETCH) ||
                          (state_nxt == S_PHASE_A && blk_nxt != LAST_BLK));
        ct_start_nxt    = enter && (state_nxt == S_PHASE_A);
        cs_start_nxt    = enter && (state_nxt == S_PHASE_B);
        write_start_nxt = enter && ((state_nxt == S_PHASE_B && blk_nxt != '0) ||
                          (state_nxt == S_LO_WRITE));
        done_nxt        = enter && (state_nxt == S_FINISH);
        busy_nxt        = (state_nxt != S_IDLE);
        sram_sel_nxt    = (state_nxt == S_PHASE_B) || (state_nxt == S_LO_WRITE);
        // The write address is staged one phase ahead of its write_start
        q_pop           = enter && ((state_nxt == S_PHASE_A && blk_nxt != '0) ||
                          (state_nxt == S_LO_WRITE));
        flag_f_nxt      = enter ? 1'b0 : (flag_f  | (fetch_done & iss_f));
        flag_ct_nxt     = enter ? 1'b0 : (flag_ct | (ct_done    & iss_ct));
        flag_cs_nxt     = enter ? 1'b0 : (flag_cs | (cs_done    & iss_cs));
        flag_w_nxt      = enter ? 1'b0 : (flag_w  | (write_done & iss_w));
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            blk         <= '0;
            flag_f      <= 1'b0;
            flag_ct     <= 1'b0;
            flag_cs     <= 1'b0;
            flag_w      <= 1'b0;
            fetch_start <= 1'b0;
            ct_start    <= 1'b0;
            cs_start    <= 1'b0;
            write_start <= 1'b0;
            Done        <= 1'b0;
            Busy        <= 1'b0;
            sram_sel    <= 1'b0;
        end else begin
            state       <= state_nxt;
            blk         <= blk_nxt;
            flag_f      <= flag_f_nxt;
            flag_ct     <= flag_ct_nxt;
            flag_cs     <= flag_cs_nxt;
            flag_w      <= flag_w_nxt;
            fetch_start <= fetch_start_nxt;
            ct_start    <= ct_start_nxt;
            cs_start    <= cs_start_nxt;
            write_start <= write_start_nxt;
            Done        <= done_nxt;
            Busy        <= busy_nxt;
            sram_sel    <= sram_sel_nxt;
        end
    end

    // Per-segment geometry: row steps are 8 rows of the segment's stride
    always_comb begin
        last_col     = (f_seg == 2'd0) ? 6'd39 : 6'd19;
        f_stride_cur = (f_seg == 2'd0) ? FSW'(320) : FSW'(160);
        w_stride_cur = (f_seg == 2'd0) ? WSW'(160) : WSW'(80);
        f_row_step   = (f_seg == 2'd0) ? AW'(2560) : AW'(1280);
        w_row_step   = (f_seg == 2'd0) ? AW'(1280) : AW'(640);
        f_seg_base   = (f_seg == 2'd0) ? F_BASE_U : F_BASE_V;
        w_seg_base   = (f_seg == 2'd0) ? W_BASE_U : W_BASE_V;
    end

    // Block walker and write-address delay queue
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            f_seg        <= '0;
            f_row        <= '0;
            f_col        <= '0;
            f_row_addr   <= F_BASE_Y;
            f_addr       <= F_BASE_Y;
            w_row_addr   <= W_BASE_Y;
            w_addr       <= W_BASE_Y;
            fetch_addr   <= '0;
            fetch_stride <= '0;
            write_addr   <= '0;
            write_stride <= '0;
            q_addr[0]    <= '0;
            q_addr[1]    <= '0;
            q_stride[0]  <= '0;
            q_stride[1]  <= '0;
            q_cnt        <= '0;
        end else begin
            if (fetch_start_nxt) begin
                fetch_addr   <= f_addr;
                fetch_stride <= f_stride_cur;
                if (f_col != last_col) begin
                    f_col  <= f_col + 6'd1;
                    f_addr <= f_addr + AW'(8);
                    w_addr <= w_addr + AW'(4);
                end else if (f_row != ROW_LAST) begin
                    f_col      <= '0;
                    f_row      <= f_row + 5'd1;
                    f_row_addr <= f_row_addr + f_row_step;
                    f_addr     <= f_row_addr + f_row_step;
                    w_row_addr <= w_row_addr + w_row_step;
                    w_addr     <= w_row_addr + w_row_step;
                end else begin
                    f_col      <= '0;
                    f_row      <= '0;
                    f_seg      <= f_seg + 2'd1;
                    f_row_addr <= f_seg_base;
                    f_addr     <= f_seg_base;
                    w_row_addr <= w_seg_base;
                    w_addr     <= w_seg_base;
                end
            end else if (state == S_FINISH) begin
                f_seg      <= '0;
                f_row      <= '0;
                f_col      <= '0;
                f_row_addr <= F_BASE_Y;
                f_addr     <= F_BASE_Y;
                w_row_addr <= W_BASE_Y;
                w_addr     <= W_BASE_Y;
            end
            if (q_pop) begin
                write_addr   <= q_addr[0];
                write_stride <= q_stride[0];
            end
            case ({fetch_start_nxt, q_pop})
                2'b01: begin
                    q_addr[0]   <= q_addr[1];
                    q_stride[0] <= q_stride[1];
                    q_cnt       <= q_cnt - 2'd1;
                end
                2'b10: begin
                    if (q_cnt == 2'd0) begin
                        q_addr[0]   <= w_addr;
                        q_stride[0] <= w_stride_cur;
                    end else begin
                        q_addr[1]   <= w_addr;
                        q_stride[1] <= w_stride_cur;
                    end
                    q_cnt <= q_cnt + 2'd1;
                end
                2'b11: begin
                    if (q_cnt == 2'd2) begin
                        q_addr[0]   <= q_addr[1];
                        q_stride[0] <= q_stride[1];
                        q_addr[1]   <= w_addr;
                        q_stride[1] <= w_stride_cur;
                    end else begin
                        q_addr[0]   <= w_addr;
                        q_stride[0] <= w_stride_cur;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_m2_block_scheduler.sv
// Scoreboard bench for m2_block_scheduler: expected fetch/write descriptors are
// queued by the stimulus and popped by a monitor on every start pulse.
module tb_m2_block_scheduler;
    localparam int LAT_F  = 5;
    localparam int LAT_CT = 5;
    localparam int LAT_CS = 4;
    localparam int LAT_W  = 6;
    localparam int NBLK   = 2400;

    typedef struct { int blk; int addr; int stride; } exp_t;

    logic        Clock = 1'b0;
    logic        Reset, Enable;
    logic        Done, Busy, fetch_start, ct_start, cs_start, write_start, sram_sel;
    logic [17:0] fetch_addr, write_addr;
    logic [8:0]  fetch_stride;
    logic [7:0]  write_stride;
    logic        fetch_done, ct_done, cs_done, write_done;
    logic        eng_f, eng_ct, eng_cs, eng_w;
    logic        spur_f, spur_ct, spur_w;

    assign fetch_done = eng_f | spur_f;
    assign ct_done    = eng_ct | spur_ct;
    assign cs_done    = eng_cs;
    assign write_done = eng_w | spur_w;

    m2_block_scheduler dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Done(Done), .Busy(Busy),
        .fetch_start(fetch_start), .fetch_addr(fetch_addr), .fetch_stride(fetch_stride),
        .fetch_done(fetch_done), .ct_start(ct_start), .ct_done(ct_done),
        .cs_start(cs_start), .cs_done(cs_done), .write_start(write_start),
        .write_done(write_done), .write_addr(write_addr), .write_stride(write_stride),
        .sram_sel(sram_sel)
    );

    always #5 Clock = ~Clock;

    // Engine models: one done pulse a fixed number of cycles after each start
    initial begin
        eng_f = 1'b0;
        forever begin
            @(negedge Clock);
            if (fetch_start) begin
                repeat (LAT_F) @(negedge Clock);
                eng_f = 1'b1; @(negedge Clock); eng_f = 1'b0;
            end
        end
    end
    initial begin
        eng_ct = 1'b0;
        forever begin
            @(negedge Clock);
            if (ct_start) begin
                repeat (LAT_CT) @(negedge Clock);
                eng_ct = 1'b1; @(negedge Clock); eng_ct = 1'b0;
            end
        end
    end
    initial begin
        eng_cs = 1'b0;
        forever begin
            @(negedge Clock);
            if (cs_start) begin
                repeat (LAT_CS) @(negedge Clock);
                eng_cs = 1'b1; @(negedge Clock); eng_cs = 1'b0;
            end
        end
    end
    initial begin
        eng_w = 1'b0;
        forever begin
            @(negedge Clock);
            if (write_start) begin
                repeat (LAT_W) @(negedge Clock);
                eng_w = 1'b1; @(negedge Clock); eng_w = 1'b0;
            end
        end
    end

    int   n_cmp, n_err;
    int   tcyc, n_fetch, n_ct, n_cs, n_write, n_done;
    int   last_f_cyc, last_ct_cyc, last_cs_cyc, last_w_cyc;
    bit   f_active, w_active;
    logic [17:0] held_f, held_w;
    exp_t exp_f[$];
    exp_t exp_w[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference addressing straight from the frame geometry
    function automatic void model(input int n, output int fa, output int fs,
                                  output int wa, output int ws);
        int r, c;
        if (n < 1200) begin
            r = n / 40; c = n % 40; fs = 320; ws = 160;
            fa = 76800 + r * 8 * fs + c * 8;  wa = r * 8 * ws + c * 4;
        end else if (n < 1800) begin
            r = (n - 1200) / 20; c = (n - 1200) % 20; fs = 160; ws = 80;
            fa = 153600 + r * 8 * fs + c * 8; wa = 38400 + r * 8 * ws + c * 4;
        end else begin
            r = (n - 1800) / 20; c = (n - 1800) % 20; fs = 160; ws = 80;
            fa = 192000 + r * 8 * fs + c * 8; wa = 57600 + r * 8 * ws + c * 4;
        end
    endfunction

    function automatic bit hand_fetch(input int n, output int a, output int s);
        a = 0; s = 0;
        case (n)
            0:       begin a = 76800;  s = 320; end
            1:       begin a = 76808;  s = 320; end
            39:      begin a = 77112;  s = 320; end
            40:      begin a = 79360;  s = 320; end
            1200:    begin a = 153600; s = 160; end
            2399:    begin a = 229272; s = 160; end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic bit hand_write(input int n, output int a, output int s);
        a = 0; s = 0;
        case (n)
            0:       begin a = 0;     s = 160; end
            40:      begin a = 1280;  s = 160; end
            1199:    begin a = 37276; s = 160; end
            1200:    begin a = 38400; s = 80;  end
            2399:    begin a = 76236; s = 80;  end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic push_all();
        int fa, fs, wa, ws;
        exp_f.delete(); exp_w.delete();
        for (int n = 0; n < NBLK; n++) begin
            model(n, fa, fs, wa, ws);
            exp_f.push_back('{blk: n, addr: fa, stride: fs});
            exp_w.push_back('{blk: n, addr: wa, stride: ws});
        end
        n_fetch = 0; n_ct = 0; n_cs = 0; n_write = 0; n_done = 0;
    endtask

    task automatic monitor();
        exp_t e;
        int ha, hs;
        forever begin
            @(negedge Clock);
            tcyc++;
            if (Reset) begin
                f_active = 1'b0; w_active = 1'b0;
                continue;
            end
            if (ct_start) begin
                if (n_ct == 0) check("gap_li_to_a", 64'(tcyc - last_f_cyc), 64'(LAT_F + 2));
                else check($sformatf("gap_b_to_a[%0d]", n_ct), 64'(tcyc - last_cs_cyc),
                           64'((n_ct == 1) ? LAT_CS + 2 : LAT_W + 2));
                check($sformatf("fetch_with_ct[%0d]", n_ct), 64'(fetch_start), 64'(n_ct != NBLK - 1));
                check("sram_sel_phase_a", 64'(sram_sel), 64'(0));
                n_ct++; last_ct_cyc = tcyc; w_active = 1'b0;
            end
            if (cs_start) begin
                check($sformatf("gap_a_to_b[%0d]", n_cs), 64'(tcyc - last_ct_cyc), 64'(LAT_CT + 2));
                check($sformatf("write_with_cs[%0d]", n_cs), 64'(write_start), 64'(n_cs != 0));
                check("sram_sel_phase_b", 64'(sram_sel), 64'(1));
                n_cs++; last_cs_cyc = tcyc; f_active = 1'b0;
            end
            if (Done) begin
                check("gap_lo_to_done", 64'(tcyc - last_w_cyc), 64'(LAT_W + 2));
                n_done++; w_active = 1'b0;
            end
            if (fetch_start) begin
                check("fetch_expected", 64'(exp_f.size() != 0), 64'(1));
                if (exp_f.size() != 0) begin
                    e = exp_f.pop_front();
                    check($sformatf("fetch_addr[%0d]", e.blk), 64'(fetch_addr), 64'(e.addr));
                    check($sformatf("fetch_stride[%0d]", e.blk), 64'(fetch_stride), 64'(e.stride));
                    if (hand_fetch(e.blk, ha, hs)) begin
                        check($sformatf("vec_fetch_addr[%0d]", e.blk), 64'(fetch_addr), 64'(ha));
                        check($sformatf("vec_fetch_stride[%0d]", e.blk), 64'(fetch_stride), 64'(hs));
                    end
                end
                n_fetch++; f_active = 1'b1; held_f = fetch_addr; last_f_cyc = tcyc;
            end else if (f_active) begin
                check("fetch_addr_stable", 64'(fetch_addr), 64'(held_f));
            end
            if (write_start) begin
                check("sram_sel_write", 64'(sram_sel), 64'(1));
                check("write_expected", 64'(exp_w.size() != 0), 64'(1));
                if (exp_w.size() != 0) begin
                    e = exp_w.pop_front();
                    check($sformatf("write_addr[%0d]", e.blk), 64'(write_addr), 64'(e.addr));
                    check($sformatf("write_stride[%0d]", e.blk), 64'(write_stride), 64'(e.stride));
                    if (hand_write(e.blk, ha, hs)) begin
                        check($sformatf("vec_write_addr[%0d]", e.blk), 64'(write_addr), 64'(ha));
                        check($sformatf("vec_write_stride[%0d]", e.blk), 64'(write_stride), 64'(hs));
                    end
                end
                n_write++; w_active = 1'b1; held_w = write_addr; last_w_cyc = tcyc;
            end else if (w_active) begin
                check("write_addr_stable", 64'(write_addr), 64'(held_w));
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({Done, Busy, fetch_start, ct_start, cs_start, write_start, sram_sel,
                         fetch_addr, fetch_stride, write_addr, write_stride}), 64'(0));
    endtask

    task automatic pulse_enable();
        @(negedge Clock); Enable = 1'b1;
        @(negedge Clock); Enable = 1'b0;
    endtask

    task automatic stimulus();
        repeat (3) @(negedge Clock);
        check_all_zero("reset_outputs");
        @(negedge Clock); Reset = 1'b0;

        // Run 1: abort with Reset in the middle of PHASE_B of block 7
        push_all();
        pulse_enable();
        for (int i = 0; i < 3000 && n_cs < 8; i++) @(negedge Clock);
        check("reach_phase_b7", 64'(n_cs >= 8), 64'(1));
        @(negedge Clock); Reset = 1'b1;
        @(negedge Clock);
        check_all_zero("abort_outputs");
        repeat (12) begin
            @(negedge Clock);
            check_all_zero("abort_hold");
        end
        @(negedge Clock); Reset = 1'b0;

        // Run 2: full frame, with spurious done pulses and a stray Enable
        push_all();
        pulse_enable();
        for (int i = 0; i < 1000 && n_ct < 4; i++) @(negedge Clock);
        @(negedge Clock); spur_w = 1'b1;
        @(negedge Clock); spur_w = 1'b0;
        for (int i = 0; i < 1000 && n_cs < 4; i++) @(negedge Clock);
        @(negedge Clock); spur_ct = 1'b1; spur_f = 1'b1;
        @(negedge Clock); spur_ct = 1'b0; spur_f = 1'b0;
        for (int i = 0; i < 1000 && n_ct < 6; i++) @(negedge Clock);
        pulse_enable();
        for (int i = 0; i < 40000 && n_done < 1; i++) @(negedge Clock);
        check("done_seen", 64'(n_done), 64'(1));
        @(negedge Clock);
        check("busy_after_done", 64'(Busy), 64'(0));
        check("fetch_count", 64'(n_fetch), 64'(NBLK));
        check("ct_count", 64'(n_ct), 64'(NBLK));
        check("cs_count", 64'(n_cs), 64'(NBLK));
        check("write_count", 64'(n_write), 64'(NBLK));
        repeat (5) @(negedge Clock);
        check("single_done", 64'(n_done), 64'(1));
        check("idle_busy", 64'(Busy), 64'(0));
        check("fetch_queue_drained", 64'(exp_f.size()), 64'(0));
        check("write_queue_drained", 64'(exp_w.size()), 64'(0));
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0;
        spur_f = 1'b0; spur_ct = 1'b0; spur_w = 1'b0;
        n_cmp = 0; n_err = 0; tcyc = 0;
        n_fetch = 0; n_ct = 0; n_cs = 0; n_write = 0; n_done = 0;
        last_f_cyc = 0; last_ct_cyc = 0; last_cs_cyc = 0; last_w_cyc = 0;
        f_active = 1'b0; w_active = 1'b0; held_f = '0; held_w = '0;
        fork
            monitor();
            stimulus();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
